// File: rtl/pkt_rx_pkg.sv
// rtl/pkt_rx_pkg.sv - shared types, header field layout and extract helpers for the packet receive parser
package pkt_rx_pkg;

  localparam int HDR_ADDR_W = 2;
  localparam int HDR_LEN_W  = 6;
  localparam int ENTRY_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } entry_t;

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_W-1:0];
  endfunction

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:HDR_ADDR_W];
  endfunction

endpackage

// File: rtl/pkt_rx_parser_if.sv
// rtl/pkt_rx_parser_if.sv - byte stream in, framed byte stream out, error pulses and counters
interface pkt_rx_parser_if #(
  parameter int CNT_W = 16
) ();

  logic             packet_valid;
  logic [7:0]       data_in;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_sop;
  logic             out_eop;
  logic             parity_err;
  logic             len_err;
  logic             ovf_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  modport slave (
    input  packet_valid, data_in, out_ready,
    output out_valid, out_data, out_sop, out_eop,
    output parity_err, len_err, ovf_err, pkt_cnt, drop_cnt, busy
  );

  modport master (
    output packet_valid, data_in, out_ready,
    input  out_valid, out_data, out_sop, out_eop,
    input  parity_err, len_err, ovf_err, pkt_cnt, drop_cnt, busy
  );

endinterface

// File: rtl/pkt_sync_fifo.sv
// rtl/pkt_sync_fifo.sv - synchronous {sop, eop, data} output buffer with occupancy count
module pkt_sync_fifo
  import pkt_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full buffer refuses the push even when a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_rx_parser.sv
// rtl/pkt_rx_parser.sv - header/payload/parity packet parser feeding a framed output buffer
module pkt_rx_parser
  import pkt_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  pkt_rx_parser_if.slave bus
);

  state_t           state;
  state_t           state_d;
  logic [6:0]       cnt;
  logic [6:0]       cnt_d;
  logic [7:0]       par;
  logic [7:0]       par_d;
  logic [5:0]       len;
  logic [5:0]       len_d;
  logic [6:0]       len_ext;
  logic             push;
  entry_t           push_entry;
  entry_t           head;
  logic             full;
  logic             empty;
  logic             perr_d;
  logic             lerr_d;
  logic             ovf_d;
  logic             pkt_inc;
  logic             perr_q;
  logic             lerr_q;
  logic             ovf_q;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;

  assign len_ext = {1'b0, len};
  assign ovf_d   = push && full;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    par_d      = par;
    len_d      = len;
    push       = 1'b0;
    push_entry = '0;
    perr_d     = 1'b0;
    lerr_d     = 1'b0;
    pkt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.packet_valid) begin
          push            = 1'b1;
          push_entry.sop  = 1'b1;
          push_entry.eop  = (hdr_len(bus.data_in) == '0);
          push_entry.data = bus.data_in;
          len_d           = hdr_len(bus.data_in);
          cnt_d           = '0;
          par_d           = bus.data_in;
          state_d         = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (bus.packet_valid) begin
          par_d = par ^ bus.data_in;
          // Saturates so a runaway stream still reads as a length mismatch.
          if (cnt != 7'h7F) begin
            cnt_d = cnt + 7'd1;
          end
          if (cnt < len_ext) begin
            push            = 1'b1;
            push_entry.eop  = ((cnt + 7'd1) == len_ext);
            push_entry.data = bus.data_in;
          end
        end else begin
          perr_d  = (bus.data_in != par);
          lerr_d  = (cnt != len_ext);
          // Short packet: close the frame with a zero pad carrying eop.
          if (cnt < len_ext) begin
            push           = 1'b1;
            push_entry.eop = 1'b1;
          end
          pkt_inc = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      par      <= '0;
      len      <= '0;
      perr_q   <= 1'b0;
      lerr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      par    <= par_d;
      len    <= len_d;
      perr_q <= perr_d;
      lerr_q <= lerr_d;
      ovf_q  <= ovf_d;
      if (pkt_inc && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
      if (ovf_d && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  pkt_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (bus.out_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign bus.out_valid  = !empty;
  assign bus.out_data   = head.data;
  assign bus.out_sop    = head.sop;
  assign bus.out_eop    = head.eop;
  assign bus.parity_err = perr_q;
  assign bus.len_err    = lerr_q;
  assign bus.ovf_err    = ovf_q;
  assign bus.pkt_cnt    = pkt_cnt;
  assign bus.drop_cnt   = drop_cnt;
  assign bus.busy       = (state != ST_IDLE);

endmodule
